// File: rtl/perf_sample_ctrl.sv
`default_nettype none
// ============================================================================
// perf_sample_ctrl : run/stop/snapshot/readout sequencer for the perf-counter bank
// Revision 1.0
// ============================================================================
module perf_sample_ctrl #(
  parameter int NCNT   = 4,
  parameter int W      = 32,
  parameter int MAXCYC = 0,
  localparam int IW    = (NCNT > 1) ? $clog2(NCNT) : 1
) (
  input  logic              in_CLK,
  input  logic              in_RST_N,
  input  logic              in_START,
  input  logic              in_STOP,
  input  logic              in_ABORT,
  input  logic              in_HALT,
  input  logic [NCNT*W-1:0] in_CNT_DATA,
  input  logic              in_READY,
  output logic              out_CNT_CLR,
  output logic              out_CNT_EN,
  output logic              out_VALID,
  output logic [W-1:0]      out_DATA,
  output logic [IW-1:0]     out_IDX,
  output logic [W-1:0]      out_CYC,
  output logic              out_BUSY,
  output logic              out_DONE
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_SNAP  = 3'd3;
  localparam logic [2:0] S_SCAN  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [W-1:0]  MAXCYC_W = W'(MAXCYC);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCNT - 1);

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  cyc_q, cyc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  snap_q [NCNT];
  logic [W-1:0]  snap_d [NCNT];

  logic [W-1:0]  cyc_inc;
  logic          auto_stop;
  logic          last_word;

  assign cyc_inc   = cyc_q + W'(1);
  // Auto-stop fires on the edge that brings the enabled-cycle count to MAXCYC.
  assign auto_stop = (MAXCYC != 0) && out_CNT_EN && (cyc_inc == MAXCYC_W);
  assign last_word = (idx_q == LAST_IDX);

  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (in_ABORT) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (in_START) state_d = S_CLEAR;
        S_CLEAR: state_d = S_RUN;
        S_RUN:   if (in_STOP || auto_stop) state_d = S_SNAP;
        S_SNAP:  state_d = S_SCAN;
        S_SCAN:  if (in_READY && last_word) state_d = S_DONE;
        S_DONE:  if (in_START) state_d = S_CLEAR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Abort leaves the cycle count, index and snapshot untouched.
  always_comb begin
    cyc_d  = cyc_q;
    idx_d  = idx_q;
    snap_d = snap_q;
    if (!in_ABORT) begin
      if (state_d == S_CLEAR) begin
        cyc_d = '0;
      end else if ((state_q == S_RUN) && out_CNT_EN) begin
        cyc_d = cyc_inc;
      end
      if (state_q == S_SNAP) begin
        idx_d = '0;
        for (int k = 0; k < NCNT; k++) begin
          snap_d[k] = in_CNT_DATA[k*W +: W];
        end
      end else if ((state_q == S_SCAN) && in_READY && !last_word) begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_comb begin
    out_CNT_CLR = (state_q == S_CLEAR);
    out_CNT_EN  = (state_q == S_RUN) && !in_HALT;
    out_VALID   = (state_q == S_SCAN);
    out_DONE    = (state_q == S_DONE);
    out_BUSY    = (state_q == S_CLEAR) || (state_q == S_RUN) ||
                  (state_q == S_SNAP)  || (state_q == S_SCAN);
  end

  assign out_DATA = snap_q[idx_q];
  assign out_IDX  = idx_q;
  assign out_CYC  = cyc_q;

endmodule
`default_nettype wire

// File: tb/tb_perf_sample_ctrl.sv
`default_nettype none
// tb_perf_sample_ctrl : directed stimulus with a queue scoreboard on the readout stream.
module tb_perf_sample_ctrl;

  localparam int NCNT = 4;
  localparam int W    = 32;
  localparam int IW   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, stop, abort, halt, ready;
  logic [NCNT*W-1:0] cnt_data;
  logic              cnt_clr, cnt_en, valid, busy, done;
  logic [W-1:0]      data, cyc;
  logic [IW-1:0]     idx;

  logic              rst_m_n, start_m, stop_m;
  logic              clr_m, en_m, valid_m, busy_m, done_m;
  logic [W-1:0]      data_m, cyc_m;
  logic [IW-1:0]     idx_m;

  perf_sample_ctrl #(.NCNT(NCNT), .W(W), .MAXCYC(0)) dut (
    .in_CLK(clk), .in_RST_N(rst_n), .in_START(start), .in_STOP(stop),
    .in_ABORT(abort), .in_HALT(halt), .in_CNT_DATA(cnt_data), .in_READY(ready),
    .out_CNT_CLR(cnt_clr), .out_CNT_EN(cnt_en), .out_VALID(valid),
    .out_DATA(data), .out_IDX(idx), .out_CYC(cyc), .out_BUSY(busy), .out_DONE(done)
  );

  perf_sample_ctrl #(.NCNT(NCNT), .W(W), .MAXCYC(8)) dut_m (
    .in_CLK(clk), .in_RST_N(rst_m_n), .in_START(start_m), .in_STOP(stop_m),
    .in_ABORT(abort), .in_HALT(halt), .in_CNT_DATA(cnt_data), .in_READY(ready),
    .out_CNT_CLR(clr_m), .out_CNT_EN(en_m), .out_VALID(valid_m),
    .out_DATA(data_m), .out_IDX(idx_m), .out_CYC(cyc_m), .out_BUSY(busy_m), .out_DONE(done_m)
  );

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [W-1:0]  data;
  } word_t;

  word_t exp_q[$];
  int    errors  = 0;
  int    checks  = 0;
  int    en_cnt  = 0;
  int    clr_cnt = 0;
  int    acc_cnt = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bank(input logic [W-1:0] a, b, c, d);
    cnt_data = {d, c, b, a};
  endtask

  task automatic push_word(input int k);
    word_t w;
    w.idx  = IW'(k);
    w.data = cnt_data[k*W +: W];
    exp_q.push_back(w);
  endtask

  task automatic push_bank();
    for (int k = 0; k < NCNT; k++) push_word(k);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 40 && !done; i++) tick();
    chk(name, W'(done), W'(1));
  endtask

  // Monitor: counts enable/clear cycles and checks every accepted readout word.
  initial begin
    logic          hold_pend;
    logic [W-1:0]  hold_d;
    logic [IW-1:0] hold_i;
    word_t         e;
    hold_pend = 1'b0;
    forever begin
      @(negedge clk);
      en_cnt  += int'(cnt_en);
      clr_cnt += int'(cnt_clr);
      if (valid) begin
        if (hold_pend) begin
          chk("hold_data", data, hold_d);
          chk("hold_idx", W'(idx), W'(hold_i));
        end
        if (ready) begin
          acc_cnt++;
          hold_pend = 1'b0;
          chk("word_expected", W'(exp_q.size() > 0), W'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_idx", W'(idx), W'(e.idx));
            chk("sb_data", data, e.data);
          end
        end else begin
          hold_pend = 1'b1;
          hold_d    = data;
          hold_i    = idx;
        end
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  task automatic run_m(input bit with_stop, input string tag);
    start_m = 1'b1; tick(); start_m = 1'b0;
    chk({tag, "_clr"}, W'(clr_m), W'(1));
    chk({tag, "_cyc0"}, cyc_m, W'(0));
    tick();
    repeat (7) tick();
    chk({tag, "_cyc7"}, cyc_m, W'(7));
    chk({tag, "_en8"}, W'(en_m), W'(1));
    stop_m = with_stop;
    tick();
    stop_m = 1'b0;
    chk({tag, "_snap_cyc"}, cyc_m, W'(8));
    chk({tag, "_snap_en"}, W'(en_m), W'(0));
    chk({tag, "_snap_valid"}, W'(valid_m), W'(0));
    chk({tag, "_snap_busy"}, W'(busy_m), W'(1));
    tick();
    chk({tag, "_scan_valid"}, W'(valid_m), W'(1));
    chk({tag, "_scan_idx"}, W'(idx_m), W'(0));
    chk({tag, "_scan_data"}, data_m, cnt_data[W-1:0]);
    ready = 1'b1;
    for (int i = 0; i < 20 && !done_m; i++) tick();
    chk({tag, "_done"}, W'(done_m), W'(1));
    chk({tag, "_done_cyc"}, cyc_m, W'(8));
    ready = 1'b0;
  endtask

  initial begin
    int e0, c0, a0;
    rst_n = 1'b0; rst_m_n = 1'b0;
    start = 1'b0; stop = 1'b0; abort = 1'b0; halt = 1'b0; ready = 1'b0;
    start_m = 1'b0; stop_m = 1'b0;
    cnt_data = '0;
    repeat (3) tick();

    chk("rst_valid", W'(valid), W'(0));
    chk("rst_clr", W'(cnt_clr), W'(0));
    chk("rst_en", W'(cnt_en), W'(0));
    chk("rst_cyc", cyc, W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_idx", W'(idx), W'(0));
    chk("rst_data", data, W'(0));
    rst_n = 1'b1;
    tick();

    // Window 1: START (with simultaneous STOP) then 10 enabled cycles.
    set_bank(5, 7, 9, 11);
    e0 = en_cnt; c0 = clr_cnt;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("t1_clr", W'(cnt_clr), W'(1));
    chk("t1_clr_cyc", cyc, W'(0));
    chk("t1_clr_en", W'(cnt_en), W'(0));
    tick();
    repeat (9) tick();
    stop = 1'b1; push_bank(); ready = 1'b1;
    tick();
    stop = 1'b0;
    chk("t1_snap_busy", W'(busy), W'(1));
    chk("t1_snap_en", W'(cnt_en), W'(0));
    chk("t1_snap_valid", W'(valid), W'(0));
    chk("t1_snap_cyc", cyc, W'(10));
    chk("t1_en_cycles", W'(en_cnt - e0), W'(10));
    chk("t1_clr_cycles", W'(clr_cnt - c0), W'(1));
    a0 = acc_cnt;
    tick();
    chk("t1_scan_valid", W'(valid), W'(1));
    repeat (4) tick();
    chk("t1_done", W'(done), W'(1));
    chk("t1_done_valid", W'(valid), W'(0));
    chk("t1_words", W'(acc_cnt - a0), W'(4));
    chk("t1_done_cyc", cyc, W'(10));

    // Window 2: START from DONE, READY toggling, bank changes after SNAP.
    ready = 1'b0;
    set_bank(100, 200, 300, 400);
    start = 1'b1; tick(); start = 1'b0;
    chk("t2_clr", W'(cnt_clr), W'(1));
    chk("t2_cyc_restart", cyc, W'(0));
    tick();
    repeat (2) tick();
    stop = 1'b1; push_bank(); tick(); stop = 1'b0;
    chk("t2_snap_cyc", cyc, W'(3));
    a0 = acc_cnt;
    tick();
    set_bank(32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'hDEAD_0004);
    for (int i = 0; i < 40 && !done; i++) begin
      ready = (i >= 2) && (i % 2 == 0);
      cnt_data = cnt_data + 1;
      tick();
    end
    chk("t2_done", W'(done), W'(1));
    chk("t2_words", W'(acc_cnt - a0), W'(4));

    // Window 3: HALT high for cycles 4..6 of 12.
    ready = 1'b1;
    set_bank(1, 2, 3, 4);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    e0 = en_cnt;
    for (int i = 1; i <= 12; i++) begin
      halt = (i >= 4) && (i <= 6);
      if (i == 12) begin
        stop = 1'b1;
        push_bank();
      end
      #1;
      chk("t3_en", W'(cnt_en), W'(!halt));
      chk("t3_busy", W'(busy), W'(1));
      tick();
    end
    halt = 1'b0; stop = 1'b0;
    chk("t3_cyc", cyc, W'(9));
    chk("t3_en_cycles", W'(en_cnt - e0), W'(9));
    tick();
    wait_done("t3_done");

    // Window 4: ABORT while word 2 is offered.
    set_bank(21, 22, 23, 24);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    repeat (4) tick();
    stop = 1'b1; push_word(0); push_word(1); tick(); stop = 1'b0;
    tick();
    tick();
    tick();
    ready = 1'b0; abort = 1'b1;
    chk("t4_idx", W'(idx), W'(2));
    chk("t4_data", data, W'(23));
    tick();
    abort = 1'b0;
    chk("t4_valid", W'(valid), W'(0));
    chk("t4_busy", W'(busy), W'(0));
    chk("t4_done", W'(done), W'(0));
    chk("t4_cyc_kept", cyc, W'(5));

    // Window 5: asynchronous reset in the middle of RUN.
    start = 1'b1; tick(); start = 1'b0;
    tick();
    repeat (3) tick();
    chk("t5_en_before", W'(cnt_en), W'(1));
    chk("t5_cyc_before", cyc, W'(3));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_en_rst", W'(cnt_en), W'(0));
    chk("t5_cyc_rst", cyc, W'(0));
    chk("t5_busy_rst", W'(busy), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t5_idle", W'(busy), W'(0));

    // MAXCYC=8 instance: plain auto-stop, then STOP coinciding with it.
    rst_m_n = 1'b1;
    tick();
    set_bank(41, 42, 43, 44);
    run_m(1'b0, "m_auto");
    run_m(1'b1, "m_stop");

    chk("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
